// File: rtl/gesture_cfg_seq.sv
// gesture_cfg_seq: transaction sequencer for the gesture sensor's byte-level
// I2C master. It wakes the sensor, writes the init table one register per
// transaction (with bounded retry on NACK), then polls the gesture flag
// register and reports non-zero readings.
module gesture_cfg_seq #(
  parameter int         CLK_FREQ_HZ  = 50_000_000,
  parameter int         WAKE_WAIT_US = 1000,
  parameter int         POLL_US      = 10000,
  parameter logic [7:0] INIT_NUM     = 8'd51,
  parameter logic [1:0] MAX_RETRY    = 2'd3,
  parameter logic [7:0] GEST_REG     = 8'h43
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic [7:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        i2c_start,
  output logic        i2c_wr,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  input  logic [7:0]  i2c_rdata,
  output logic        init_done,
  output logic        gest_valid,
  output logic [7:0]  gest_data,
  output logic        err
);

  localparam logic [31:0] TICK_LAST = 32'(CLK_FREQ_HZ / 1_000_000 - 1);
  localparam logic [31:0] WAKE_LAST = 32'(WAKE_WAIT_US - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_US - 1);
  localparam logic [7:0]  LAST_IDX  = INIT_NUM - 8'd1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAKE      = 4'd1,
    S_WAKE_WAIT = 4'd2,
    S_CFG_LOAD  = 4'd3,
    S_CFG_REQ   = 4'd4,
    S_CFG_WAIT  = 4'd5,
    S_POLL_WAIT = 4'd6,
    S_POLL_REQ  = 4'd7,
    S_POLL_RD   = 4'd8,
    S_FAIL      = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tick_cnt;
  logic        tick;
  logic [31:0] dly_cnt;
  logic [1:0]  retry;
  logic        busy;   // wake access issued and still outstanding

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running 1 us tick divider.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 32'd1;
  end

  // Delay counter: counts ticks since entry into the current state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                dly_cnt <= '0;
    else if (state_d != state_q) dly_cnt <= '0;
    else if (tick)              dly_cnt <= dly_cnt + 32'd1;
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; en is only looked at in IDLE, POLL_WAIT and FAIL so a
  // transaction in flight always runs to its i2c_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (en) state_d = S_WAKE;
      // The sleeping sensor NACKs the wake access, so ack_err is ignored.
      S_WAKE:      if (busy && i2c_done) state_d = S_WAKE_WAIT;
      S_WAKE_WAIT: if (tick && dly_cnt == WAKE_LAST) state_d = S_CFG_LOAD;
      S_CFG_LOAD:  state_d = S_CFG_REQ;
      S_CFG_REQ:   state_d = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (i2c_done) begin
          if (!i2c_ack_err)
            state_d = (cfg_addr == LAST_IDX) ? S_POLL_WAIT : S_CFG_LOAD;
          else if (retry < MAX_RETRY)
            state_d = S_CFG_REQ;
          else
            state_d = S_FAIL;
        end
      end
      S_POLL_WAIT: begin
        if (!en)                               state_d = S_IDLE;
        else if (tick && dly_cnt == POLL_LAST) state_d = S_POLL_REQ;
      end
      S_POLL_REQ:  state_d = S_POLL_RD;
      S_POLL_RD:   if (i2c_done) state_d = S_POLL_WAIT;
      S_FAIL:      if (!en) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Registered request/result outputs. The lookup port has one cycle of
  // latency, so cfg_data is valid in CFG_REQ (CFG_LOAD covers the latency)
  // and is captured together with the start pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cfg_addr   <= '0;
      i2c_start  <= 1'b0;
      i2c_wr     <= 1'b0;
      i2c_reg    <= '0;
      i2c_wdata  <= '0;
      init_done  <= 1'b0;
      gest_valid <= 1'b0;
      gest_data  <= '0;
      err        <= 1'b0;
      retry      <= '0;
      busy       <= 1'b0;
    end else begin
      i2c_start  <= 1'b0;
      gest_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          init_done <= 1'b0;
          busy      <= 1'b0;
          retry     <= '0;
        end
        S_WAKE: begin
          if (!busy) begin
            i2c_start <= 1'b1;
            i2c_wr    <= 1'b1;
            i2c_reg   <= 8'h00;
            i2c_wdata <= 8'h00;
            busy      <= 1'b1;
          end else if (i2c_done) begin
            busy <= 1'b0;
          end
        end
        S_WAKE_WAIT: begin
          if (state_d == S_CFG_LOAD) begin
            cfg_addr <= '0;
            retry    <= '0;
          end
        end
        S_CFG_REQ: begin
          i2c_start <= 1'b1;
          i2c_wr    <= 1'b1;
          i2c_reg   <= cfg_data[15:8];
          i2c_wdata <= cfg_data[7:0];
        end
        S_CFG_WAIT: begin
          if (i2c_done) begin
            if (!i2c_ack_err) begin
              retry <= '0;
              if (cfg_addr == LAST_IDX) init_done <= 1'b1;
              else                      cfg_addr  <= cfg_addr + 8'd1;
            end else if (retry < MAX_RETRY) begin
              retry <= retry + 2'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_POLL_WAIT: begin
          if (!en) init_done <= 1'b0;
        end
        S_POLL_REQ: begin
          i2c_start <= 1'b1;
          i2c_wr    <= 1'b0;
          i2c_reg   <= GEST_REG;
          i2c_wdata <= 8'h00;
        end
        S_POLL_RD: begin
          // A NACKed or empty read is simply dropped.
          if (i2c_done && !i2c_ack_err && i2c_rdata != 8'h00) begin
            gest_data  <= i2c_rdata;
            gest_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
